execute_pipe: RTL

Parametrised, registered execute stage for the CPU pipeline: operand forwarding, immediate select, ALU with optional saturating add/sub, iterative multiplier, and a persistent {Z,V,N} flag register. Sits between decode/regfile read and the memory stage. Uses a valid/ready handshake on both sides so multi-cycle ops and downstream stalls back-pressure decode.

---
 rtl/exec_pkg.sv | 17 +
 rtl/execute_pipe_if.sv | 18 +
 rtl/exec_mul_iter.sv | 42 ++++
 rtl/execute_pipe.sv | 118 +++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// exec_pkg: shared op encoding, FSM states, forward selects and flag bit positions for the execute stage
package exec_pkg;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRA = 4'd6,
        OP_ROR = 4'd7,
        OP_MUL = 4'd8
    } op_e;
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_WAIT} state_e;
    localparam logic [1:0] FWD_RF = 2'd0, FWD_EXMEM = 2'd1, FWD_MEMWB = 2'd2, FWD_SELF = 2'd3;
    localparam int FLAG_Z = 2, FLAG_V = 1, FLAG_N = 0;
endpackage

// File: rtl/execute_pipe_if.sv
// execute_pipe_if: issue-side and result-side handshake bundle of the execute stage
interface execute_pipe_if #(parameter int WIDTH = 16) ();
    logic in_valid, in_ready, alu_src, out_valid, out_ready, busy;
    logic [3:0] op;
    logic [1:0] fwd_sel_a, fwd_sel_b;
    logic [WIDTH-1:0] read_data_1, read_data_2, imm, exmem_data, memwb_data, alu_out, value_to_write;
    logic [2:0] flags;
    modport master (
        output in_valid, op, read_data_1, read_data_2, imm, alu_src, fwd_sel_a, fwd_sel_b,
               exmem_data, memwb_data, out_ready,
        input  in_ready, out_valid, alu_out, value_to_write, flags, busy
    );
    modport slave (
        input  in_valid, op, read_data_1, read_data_2, imm, alu_src, fwd_sel_a, fwd_sel_b,
               exmem_data, memwb_data, out_ready,
        output in_ready, out_valid, alu_out, value_to_write, flags, busy
    );
endinterface

// File: rtl/exec_mul_iter.sv
// exec_mul_iter: shift-add multiplier retiring one multiplier bit per cycle, product holds after done
module exec_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, step;
    logic [CW-1:0] cnt_q, cnt_d;
    logic run_q, run_d;
    always_comb begin
        step = acc_q + (mplier_q[0] ? mcand_q : '0);
        done = run_q && cnt_q == CW'(WIDTH - 1);
        product = run_q ? step : acc_q;
        acc_d = start ? '0 : run_q ? step : acc_q;
        mcand_d = start ? a : run_q ? mcand_q << 1 : mcand_q;
        mplier_d = start ? b : run_q ? mplier_q >> 1 : mplier_q;
        cnt_d = start ? '0 : run_q ? cnt_q + 1'b1 : cnt_q;
        run_d = start || (run_q && !done);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            mcand_q <= '0;
            mplier_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            mcand_q <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end
endmodule

// File: rtl/execute_pipe.sv
// execute_pipe: registered execute stage with forwarding, saturating ALU, iterative multiply and {Z,V,N} flags
module execute_pipe
    import exec_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit SAT_EN = 1'b1
) (
    input logic           clk,
    input logic           rst,
    execute_pipe_if.slave io
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    state_e state_q, state_d;
    logic out_valid_q, out_valid_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d, vtw_q, vtw_d, mvtw_q, mvtw_d;
    logic [2:0] flags_q, flags_d;
    logic [WIDTH-1:0] a, b_fwd, b, sum, diff, res, mul_prod;
    logic [SHW-1:0] sh;
    logic add_v, sub_v, zn_upd, v_upd, v_val;
    logic out_free, accept, mul_start, mul_done, load_alu, load_mul;
    always_comb begin
        a = io.fwd_sel_a == FWD_EXMEM ? io.exmem_data : io.fwd_sel_a == FWD_MEMWB ? io.memwb_data :
            io.fwd_sel_a == FWD_SELF ? alu_out_q : io.read_data_1;
        b_fwd = io.fwd_sel_b == FWD_EXMEM ? io.exmem_data : io.fwd_sel_b == FWD_MEMWB ? io.memwb_data :
                io.fwd_sel_b == FWD_SELF ? alu_out_q : io.read_data_2;
        b = io.alu_src ? io.imm : b_fwd;
        sh = b[SHW-1:0];
        sum = a + b;
        diff = a - b;
        add_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        sub_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    end
    always_comb begin
        res = SAT_EN && add_v ? (a[WIDTH-1] ? SMIN : SMAX) : sum;
        zn_upd = 1'b1;
        v_upd = 1'b0;
        v_val = add_v;
        case (io.op)
            OP_ADD: v_upd = 1'b1;
            OP_SUB: begin
                res = SAT_EN && sub_v ? (a[WIDTH-1] ? SMIN : SMAX) : diff;
                v_upd = 1'b1;
                v_val = sub_v;
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SLL: res = a << sh;
            OP_SRA: res = $signed(a) >>> sh;
            OP_ROR: res = WIDTH'({a, a} >> sh);
            default: zn_upd = 1'b0;
        endcase
    end
    always_comb begin
        out_free = !out_valid_q || io.out_ready;
        io.in_ready = !rst && state_q == ST_IDLE && out_free;
        accept = io.in_valid && io.in_ready;
        mul_start = accept && io.op == OP_MUL;
        load_alu = accept && io.op != OP_MUL;
        load_mul = (state_q == ST_WAIT || (state_q == ST_MUL && mul_done)) && out_free;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = mul_start ? ST_MUL : ST_IDLE;
            ST_MUL:  state_d = !mul_done ? ST_MUL : out_free ? ST_IDLE : ST_WAIT;
            ST_WAIT: state_d = out_free ? ST_IDLE : ST_WAIT;
            default: state_d = ST_IDLE;
        endcase
    end
    always_comb begin
        out_valid_d = load_alu || load_mul || (out_valid_q && !io.out_ready);
        alu_out_d = load_alu ? res : load_mul ? mul_prod : alu_out_q;
        vtw_d = load_alu ? b_fwd : load_mul ? mvtw_q : vtw_q;
        mvtw_d = mul_start ? b_fwd : mvtw_q;
        flags_d = flags_q;
        if ((load_alu && zn_upd) || load_mul) begin
            flags_d[FLAG_Z] = alu_out_d == '0;
            flags_d[FLAG_N] = alu_out_d[WIDTH-1];
        end
        if (load_alu && v_upd) flags_d[FLAG_V] = v_val;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            out_valid_q <= 1'b0;
            alu_out_q <= '0;
            vtw_q <= '0;
            mvtw_q <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            out_valid_q <= out_valid_d;
            alu_out_q <= alu_out_d;
            vtw_q <= vtw_d;
            mvtw_q <= mvtw_d;
            flags_q <= flags_d;
        end
    end
    always_comb begin
        io.busy = state_q == ST_MUL;
        io.out_valid = out_valid_q;
        io.alu_out = alu_out_q;
        io.value_to_write = vtw_q;
        io.flags = flags_q;
    end
    exec_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk(clk),
        .rst(rst),
        .start(mul_start),
        .a(a),
        .b(b),
        .done(mul_done),
        .product(mul_prod)
    );
endmodule
